// File: rtl/prbs_gen_chk.sv
// PRBS7/15/23/31 parallel generator and self-synchronising checker.
// Includes lock detection, bit-error injection and a saturating error counter.
module prbs_gen_chk #(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned ERR_CNT_W    = 16,
    parameter int unsigned LOCK_WORDS   = 4,
    parameter int unsigned UNLOCK_WORDS = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [1:0]           i_mode,
    input  logic                 i_inv,
    input  logic                 i_gen_en,
    input  logic                 i_inj_err,
    output logic [DATA_W-1:0]    o_gen_data,
    output logic                 o_gen_valid,
    input  logic                 i_chk_valid,
    input  logic [DATA_W-1:0]    i_chk_data,
    input  logic                 i_clr_cnt,
    output logic                 o_chk_locked,
    output logic                 o_err_pulse,
    output logic [ERR_CNT_W-1:0] o_err_cnt
);
    localparam int unsigned ERRS_W = $clog2(DATA_W + 1);
    localparam int unsigned GOOD_W = $clog2(LOCK_WORDS + 1);
    localparam int unsigned BAD_W  = $clog2(UNLOCK_WORDS + 1);
    localparam int unsigned SUM_W  = ERR_CNT_W + ERRS_W;

    typedef enum logic {StSearch, StLocked} state_t;

    logic [1:0]           r_mode;
    logic [30:0]          r_s;
    logic [DATA_W-1:0]    r_gen_data;
    logic                 r_gen_valid;
    logic [30:0]          r_hist;
    state_t               r_state;
    logic [GOOD_W-1:0]    r_good_cnt;
    logic [BAD_W-1:0]     r_bad_cnt;
    logic                 r_err_pulse;
    logic [ERR_CNT_W-1:0] r_err_cnt;

    logic                 w_mode_chg;
    logic [4:0]           w_msb;
    logic [4:0]           w_tap;
    logic [30:0]          w_mask;
    logic [30:0]          w_s_next;
    logic [DATA_W-1:0]    w_gen_word;
    logic [30:0]          w_hist_next;
    logic [ERRS_W-1:0]    w_errs;
    logic [SUM_W-1:0]     w_err_sum;
    logic [ERR_CNT_W-1:0] w_err_sat;
    state_t               w_state_d;
    logic [GOOD_W-1:0]    w_good_d;
    logic [BAD_W-1:0]     w_bad_d;
    logic                 w_pulse_d;
    logic [ERR_CNT_W-1:0] w_err_cnt_d;
    logic [30:0]          w_hist_d;

    assign w_mode_chg = (i_mode != r_mode);

    // w_msb = N-1, w_tap = T-1; state bits above N-1 are kept at zero by w_mask.
    always_comb begin
        case (r_mode)
            2'b00:   begin w_msb = 5'd6;  w_tap = 5'd5;  w_mask = 31'h0000_007F; end
            2'b01:   begin w_msb = 5'd14; w_tap = 5'd13; w_mask = 31'h0000_7FFF; end
            2'b10:   begin w_msb = 5'd22; w_tap = 5'd17; w_mask = 31'h007F_FFFF; end
            default: begin w_msb = 5'd30; w_tap = 5'd27; w_mask = 31'h7FFF_FFFF; end
        endcase
    end

    always_comb begin : p_gen_unroll
        logic [30:0] w_s;
        logic        w_b;
        w_s        = r_s;
        w_b        = 1'b0;
        w_gen_word = '0;
        for (int k = 0; k < DATA_W; k++) begin
            w_b           = w_s[w_msb] ^ w_s[w_tap];
            w_gen_word[k] = w_b;
            w_s           = {w_s[29:0], w_b} & w_mask;
        end
        w_s_next = w_s;
    end

    always_comb begin : p_chk_unroll
        logic [30:0] w_c;
        logic        w_rb;
        logic        w_p;
        w_c    = r_hist;
        w_rb   = 1'b0;
        w_p    = 1'b0;
        w_errs = '0;
        for (int k = 0; k < DATA_W; k++) begin
            w_rb   = i_chk_data[k] ^ i_inv;
            w_p    = w_c[w_msb] ^ w_c[w_tap];
            w_errs = w_errs + ERRS_W'(w_rb ^ w_p);
            w_c    = {w_c[29:0], w_rb} & w_mask;
        end
        w_hist_next = w_c;
    end

    assign w_err_sum = SUM_W'(r_err_cnt) + SUM_W'(w_errs);
    assign w_err_sat = (w_err_sum > SUM_W'({ERR_CNT_W{1'b1}})) ? {ERR_CNT_W{1'b1}}
                                                              : w_err_sum[ERR_CNT_W-1:0];

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_mode      <= i_mode;
            r_s         <= 31'd1;
            r_gen_data  <= '0;
            r_gen_valid <= 1'b0;
        end else if (w_mode_chg) begin
            r_mode      <= i_mode;
            r_s         <= 31'd1;
            r_gen_valid <= 1'b0;
        end else if (i_gen_en) begin
            r_s         <= w_s_next;
            r_gen_data  <= w_gen_word ^ {DATA_W{i_inv}} ^ DATA_W'(i_inj_err);
            r_gen_valid <= 1'b1;
        end else begin
            r_gen_valid <= 1'b0;
        end
    end

    always_comb begin
        w_state_d   = r_state;
        w_good_d    = r_good_cnt;
        w_bad_d     = r_bad_cnt;
        w_pulse_d   = 1'b0;
        w_err_cnt_d = r_err_cnt;
        w_hist_d    = r_hist;
        if (w_mode_chg) begin
            w_state_d = StSearch;
            w_good_d  = '0;
            w_bad_d   = '0;
            w_hist_d  = '0;
        end else if (i_chk_valid) begin
            w_hist_d = w_hist_next;
            unique case (r_state)
                StSearch: begin
                    if (w_errs != '0) begin
                        w_good_d = '0;
                    end else if (r_good_cnt == GOOD_W'(LOCK_WORDS - 1)) begin
                        w_state_d = StLocked;
                        w_good_d  = '0;
                        w_bad_d   = '0;
                    end else begin
                        w_good_d = r_good_cnt + 1'b1;
                    end
                end
                StLocked: begin
                    w_pulse_d   = (w_errs != '0);
                    w_err_cnt_d = w_err_sat;
                    if (w_errs == '0) begin
                        w_bad_d = '0;
                    end else if (r_bad_cnt == BAD_W'(UNLOCK_WORDS - 1)) begin
                        w_state_d = StSearch;
                        w_good_d  = '0;
                        w_bad_d   = '0;
                    end else begin
                        w_bad_d = r_bad_cnt + 1'b1;
                    end
                end
                default: w_state_d = StSearch;
            endcase
        end
        // Clearing wins over any errors counted in the same cycle.
        if (i_clr_cnt) begin
            w_err_cnt_d = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= StSearch;
            r_good_cnt  <= '0;
            r_bad_cnt   <= '0;
            r_err_pulse <= 1'b0;
            r_err_cnt   <= '0;
            r_hist      <= '0;
        end else begin
            r_state     <= w_state_d;
            r_good_cnt  <= w_good_d;
            r_bad_cnt   <= w_bad_d;
            r_err_pulse <= w_pulse_d;
            r_err_cnt   <= w_err_cnt_d;
            r_hist      <= w_hist_d;
        end
    end

    assign o_gen_data   = r_gen_data;
    assign o_gen_valid  = r_gen_valid;
    assign o_chk_locked = (r_state == StLocked);
    assign o_err_pulse  = r_err_pulse;
    assign o_err_cnt    = r_err_cnt;

endmodule
